// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_mem_pkg : shared RV32 memory-access encodings, FSM states and helpers.
// Revision 1.0
// ---------------------------------------------------------------------------
package rv32_mem_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_legal_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic is_legal_store(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit_if : word-wide memory request/response bus.
// Revision 1.0
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  import rv32_mem_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );

endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_align : selects the load lane from a memory word and sign/zero extends.
// Revision 1.0
// ---------------------------------------------------------------------------
module load_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_byte_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_byte_off, 3'b000} +: 8];
  assign w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : RV32 MA-stage load/store FSM with memory handshake and timeout.
// Revision 1.0
// ---------------------------------------------------------------------------
module load_store_unit
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   address,
  input  logic [XLEN-1:0]   write_data,
  output logic [XLEN-1:0]   read_data,
  output logic              busy,
  output logic              misaligned,
  output logic              access_fault,
  load_store_unit_if.master mem
);

  localparam int               c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_mem_req;
  logic               r_we;
  logic [XLEN-1:0]    r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  logic [2:0]         r_funct3;
  logic [1:0]         r_offset;
  logic [XLEN-1:0]    r_read_data;
  logic               r_misaligned;
  logic               r_access_fault;

  logic               w_idle;
  logic               w_one_op;
  logic               w_f3_ok;
  logic               w_aligned;
  logic               w_start;
  logic               w_illegal;
  logic               w_misalign;
  logic [XLEN-1:0]    w_st_data;
  logic [STRB_W-1:0]  w_st_strb;
  logic [XLEN-1:0]    w_load_data;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_one_op   = mem_read ^ mem_write;
  assign w_f3_ok    = mem_read ? is_legal_load(funct3) : is_legal_store(funct3);
  assign w_aligned  = is_aligned(funct3[1:0], address[1:0]);
  assign w_start    = w_idle && w_one_op && w_f3_ok && w_aligned;
  // Illegal encodings outrank alignment so an undefined op never reports misaligned.
  assign w_illegal  = w_idle && ((mem_read && mem_write) || (w_one_op && !w_f3_ok));
  assign w_misalign = w_idle && w_one_op && w_f3_ok && !w_aligned;

  assign busy = !RESET && (w_start || (r_state == ST_WAIT));

  always_comb begin
    w_st_data = write_data;
    w_st_strb = '1;
    case (funct3[1:0])
      2'b00: begin
        w_st_data = {4{write_data[7:0]}};
        w_st_strb = 4'b0001 << address[1:0];
      end
      2'b01: begin
        w_st_data = {2{write_data[15:0]}};
        w_st_strb = address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .i_funct3   (r_funct3),
    .i_byte_off (r_offset),
    .i_rdata    (mem.mem_rdata),
    .o_data     (w_load_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_mem_req      <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_funct3       <= '0;
      r_offset       <= '0;
      r_read_data    <= '0;
      r_misaligned   <= 1'b0;
      r_access_fault <= 1'b0;
    end else begin
      r_misaligned   <= 1'b0;
      r_access_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_state   <= ST_WAIT;
            r_mem_req <= 1'b1;
            r_we      <= mem_write;
            r_addr    <= {address[XLEN-1:2], 2'b00};
            r_wdata   <= mem_write ? w_st_data : '0;
            r_wstrb   <= mem_write ? w_st_strb : '0;
            r_funct3  <= funct3;
            r_offset  <= address[1:0];
          end else if (w_illegal) begin
            r_access_fault <= 1'b1;
          end else if (w_misalign) begin
            r_misaligned <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A response in the final counted cycle still completes normally.
          if (mem.mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            if (!r_we) begin
              r_read_data <= w_load_data;
            end
          end else if (r_cnt == c_cnt_last) begin
            r_mem_req      <= 1'b0;
            r_access_fault <= 1'b1;
            r_read_data    <= '0;
            r_state        <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign read_data     = r_read_data;
  assign misaligned    = r_misaligned;
  assign access_fault  = r_access_fault;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_wstrb = r_wstrb;

endmodule
`default_nettype wire
